dma_ctrl: RTL and testbench
===========================

DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter LEN_W, default 8, width of the transfer-length input and word counter.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 src_addr  input  8  first source word address; sampled with start.
REQ-006 dst_addr  input  8  first destination word address; sampled with start.
REQ-007 length  input  LEN_W  number of 32-bit words to copy; sampled with start.
REQ-008 m_req  output  1  bus request to the arbiter.
REQ-009 m_grant  input  1  bus grant from the arbiter.
REQ-010 m_wr  output  1  bus write strobe (1 = write, 0 = read).
REQ-011 m_address  output  8  bus address.
REQ-012 m_dout  output  32  bus write data.
REQ-013 m_din  input  32  bus read data, valid one cycle after the read address cycle.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 done  output  1  one-cycle pulse at transfer completion.
REQ-016 irq  output  1  sticky completion interrupt; present only when DMA_IRQ_EN is defined.
REQ-017 irq_clr  input  1  clears irq; present only when DMA_IRQ_EN is defined.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, READ, CAPT, WRITE and DONE.
REQ-019 IDLE: start=1 with length≠0 SHALL latch src, dst and length and go to REQ; start=1 with length=0 SHALL go directly to DONE without asserting m_req.
REQ-020 m_req SHALL be 1 in REQ, READ, CAPT and WRITE, and 0 in IDLE and DONE.
REQ-021 REQ SHALL go to READ when m_grant=1, else remain in REQ.
REQ-022 READ: m_address=src_ptr, m_wr=0; advance to CAPT only when m_grant=1, else hold.
REQ-023 CAPT: m_din SHALL be captured into a 32-bit buffer unconditionally; next state WRITE.
REQ-024 WRITE: m_address=dst_ptr, m_wr=1, m_dout=buffer; when m_grant=1, increment src_ptr and dst_ptr by 1 (modulo 256, wrapping 8'hFF to 8'h00) and decrement the counter; go to DONE if the counter was 1, else to READ; when m_grant=0, hold all outputs and state.
REQ-025 Outside READ and WRITE, m_address SHALL be 8'h00, m_wr 0 and m_dout 32'h0.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 start asserted in any state other than IDLE SHALL be ignored.
REQ-028 Latency with m_grant held at 1: done SHALL be high 3N+2 cycles after the edge that samples start, where N is length.
REQ-029 A length of all ones SHALL copy 2^LEN_W−1 words, and address wrap SHALL NOT terminate the transfer.

Reset
REQ-030 When reset_n=0 the block SHALL immediately enter IDLE and clear pointers, counter and buffer; m_req, m_wr, busy, done and irq SHALL be 0, and m_address and m_dout SHALL be 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer without a done pulse.

Configuration
REQ-032 With DMA_IRQ_EN defined, irq SHALL be set in the cycle after DONE and stay set until irq_clr=1; if set and clear coincide, the set SHALL win.
REQ-033 Without DMA_IRQ_EN, the irq and irq_clr ports and their logic SHALL be absent; done is the only completion indication.

Verification
REQ-034 Start with src=8'h10, dst=8'h80, length=3 and grant always 1 -> words at 0x10–0x12 are written to 0x80–0x82, and done pulses exactly 11 cycles after start.
REQ-035 Start with length=0 -> m_req stays 0, done pulses in the next cycle, and busy is high for 1 cycle.
REQ-036 Start with src=8'hFE, length=4 -> read addresses are FE, FF, 00, 01, in that order.
REQ-037 m_grant is low for 5 cycles in REQ and for 2 cycles during a WRITE -> outputs hold, no word is duplicated or skipped, and the data matches the source.
REQ-038 reset_n is pulsed low during CAPT -> all outputs are 0 at once, done never pulses, and a new start afterwards completes normally.
REQ-039 With DMA_IRQ_EN defined -> irq rises after done, stays set, clears on irq_clr, and when irq_clr coincides with a new completion irq remains 1.

Source files
------------

// File: rtl/dma_ctrl.sv
// ---------------------------------------------------------------------------
// dma_ctrl -- single-channel word-copy DMA engine
//
// Copies `length` 32-bit words from src_addr.. to dst_addr.. over a simple
// request/grant bus, one read followed by one write per word. Addresses are
// 8 bits and wrap modulo 256 without affecting the transfer count.
//
// Optional feature: define DMA_IRQ_EN to add the sticky irq output and its
// irq_clr input. Without it, done is the only completion indication.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle transfer request, sampled only in IDLE
//   src_addr   first source word address (sampled with start)
//   dst_addr   first destination word address (sampled with start)
//   length     number of words to copy (sampled with start)
//   m_req      bus request
//   m_grant    bus grant
//   m_wr       bus write strobe (1 = write, 0 = read)
//   m_address  bus address
//   m_dout     bus write data
//   m_din      bus read data, valid one cycle after the read address cycle
//   busy       high while the FSM is not IDLE
//   done       one-cycle pulse at completion
//   irq        sticky completion interrupt   (DMA_IRQ_EN only)
//   irq_clr    clears irq                     (DMA_IRQ_EN only)
// ---------------------------------------------------------------------------
module dma_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       src_addr,
    input  logic [7:0]       dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             m_req,
    input  logic             m_grant,
    output logic             m_wr,
    output logic [7:0]       m_address,
    output logic [31:0]      m_dout,
    input  logic [31:0]      m_din,
    output logic             busy,
    output logic             done
`ifdef DMA_IRQ_EN
    ,
    output logic             irq,
    input  logic             irq_clr
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_READ  = 3'd2,
        S_CAPT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         src_q, src_d;
    logic [7:0]         dst_q, dst_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        buf_q, buf_d;

    logic               m_req_q, m_req_d;
    logic               m_wr_q, m_wr_d;
    logic [7:0]         m_address_q, m_address_d;
    logic [31:0]        m_dout_q, m_dout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= 8'h00;
            dst_q   <= 8'h00;
            cnt_q   <= '0;
            buf_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = length;
                        state_d = S_REQ;
                    end else begin
                        // Zero-length request completes without touching the bus.
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (m_grant) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_READ: begin
                if (m_grant) begin
                    state_d = S_CAPT;
                end else begin
                    state_d = S_READ;
                end
            end
            S_CAPT: begin
                // Read data arrives the cycle after the address; take it unconditionally.
                buf_d   = m_din;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (m_grant) begin
                    src_d = src_q + 8'd1;
                    dst_d = dst_q + 8'd1;
                    cnt_d = cnt_q - LEN_W'(1);
                    // Termination follows the counter only, never the address wrap.
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next-state values so registered outputs line up with the state.
    always_comb begin
        m_req_d     = 1'b0;
        m_wr_d      = 1'b0;
        m_address_d = 8'h00;
        m_dout_d    = 32'h0000_0000;
        busy_d      = (state_d != S_IDLE);
        // done trails the DONE state by one cycle.
        done_d      = (state_q == S_DONE);
        case (state_d)
            S_REQ: begin
                m_req_d = 1'b1;
            end
            S_READ: begin
                m_req_d     = 1'b1;
                m_address_d = src_d;
            end
            S_CAPT: begin
                m_req_d = 1'b1;
            end
            S_WRITE: begin
                m_req_d     = 1'b1;
                m_wr_d      = 1'b1;
                m_address_d = dst_d;
                m_dout_d    = buf_d;
            end
            default: begin
                m_req_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_req_q     <= 1'b0;
            m_wr_q      <= 1'b0;
            m_address_q <= 8'h00;
            m_dout_q    <= 32'h0000_0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            m_req_q     <= m_req_d;
            m_wr_q      <= m_wr_d;
            m_address_q <= m_address_d;
            m_dout_q    <= m_dout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign m_req     = m_req_q;
    assign m_wr      = m_wr_q;
    assign m_address = m_address_q;
    assign m_dout    = m_dout_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef DMA_IRQ_EN
    logic irq_q, irq_d;

    // Sticky interrupt: completion sets it, irq_clr clears it, set wins a tie.
    always_comb begin
        if (state_q == S_DONE) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Interrupt register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_dma_ctrl.sv
module tb_dma_ctrl;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [7:0]       src_addr;
    logic [7:0]       dst_addr;
    logic [LEN_W-1:0] length;
    logic             m_req;
    logic             m_grant;
    logic             m_wr;
    logic [7:0]       m_address;
    logic [31:0]      m_dout;
    logic [31:0]      m_din;
    logic             busy;
    logic             done;
`ifdef DMA_IRQ_EN
    logic             irq;
    logic             irq_clr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] exp_q[$];   // {dst address, data} in expected write order
    logic [31:0] rd_q;

    dma_ctrl #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .m_req     (m_req),
        .m_grant   (m_grant),
        .m_wr      (m_wr),
        .m_address (m_address),
        .m_dout    (m_dout),
        .m_din     (m_din),
        .busy      (busy),
        .done      (done)
`ifdef DMA_IRQ_EN
        ,
        .irq       (irq),
        .irq_clr   (irq_clr)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] src_word(input logic [7:0] a);
        return {8'hD0, a, ~a, a ^ 8'h3C};
    endfunction

    // Source memory: data for a read address appears on m_din the next cycle.
    always @(posedge clk) begin
        rd_q <= (m_req && !m_wr) ? src_word(m_address) : 32'hDEAD_BEEF;
    end
    assign m_din = rd_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Write monitor: every granted write is popped against the scoreboard.
    always @(negedge clk) begin
        if (reset_n && m_req && m_wr && m_grant) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'h0, m_address}, 32'hFFFF_FFFF);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {24'h0, m_address}, {24'h0, e[39:32]});
                check("wr_data", m_dout, e[31:0]);
            end
        end
    end

    // Drive a start (caller is 1 time unit after a rising edge); returns just after the sampling edge.
    task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [LEN_W-1:0] n);
        for (int i = 0; i < int'(n); i++) begin
            logic [7:0] sa, da;
            sa = s + i[7:0];
            da = d + i[7:0];
            exp_q.push_back({da, src_word(sa)});
        end
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = n;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        length   = '0;
    endtask

    // Count rising edges (after the start edge) until done is seen; -1 on timeout.
    task automatic wait_done(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        length   = '0;
        m_grant  = 1'b1;
`ifdef DMA_IRQ_EN
        irq_clr  = 1'b0;
`endif
        #12;
        check("rst_m_req", {31'h0, m_req}, 32'h0);
        check("rst_m_wr", {31'h0, m_wr}, 32'h0);
        check("rst_m_address", {24'h0, m_address}, 32'h0);
        check("rst_m_dout", m_dout, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
`ifdef DMA_IRQ_EN
        check("rst_irq", {31'h0, irq}, 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic three-word copy, grant held high.
        do_start(8'h10, 8'h80, 8'd3);
        check("t1_busy", {31'h0, busy}, 32'h1);
        wait_done(40, k);
        check("t1_latency", k, 32'd11);
        check("t1_busy_end", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1;
        check("t1_done_pulse", {31'h0, done}, 32'h0);
        check("t1_queue_empty", exp_q.size(), 32'd0);

        // Zero length: no bus request, busy for one cycle, done next.
        do_start(8'h33, 8'h44, 8'd0);
        check("t2_busy", {31'h0, busy}, 32'h1);
        check("t2_m_req", {31'h0, m_req}, 32'h0);
        check("t2_done_early", {31'h0, done}, 32'h0);
        @(posedge clk);
        #1;
        check("t2_done", {31'h0, done}, 32'h1);
        check("t2_busy_end", {31'h0, busy}, 32'h0);
        check("t2_m_req_end", {31'h0, m_req}, 32'h0);
        @(posedge clk);
        #1;
        check("t2_done_pulse", {31'h0, done}, 32'h0);

        // Source address wraps FE, FF, 00, 01.
        do_start(8'hFE, 8'h40, 8'd4);
        wait_done(60, k);
        check("t3_latency", k, 32'd14);
        check("t3_queue_empty", exp_q.size(), 32'd0);

        // Grant withheld in REQ for 5 cycles and in WRITE for 2 cycles.
        @(posedge clk);
        #1;
        m_grant = 1'b0;
        do_start(8'h50, 8'hC0, 8'd3);
        for (int i = 0; i < 5; i++) begin
            check("t4_req_hold", {23'h0, m_req, m_wr, m_address}, {23'h0, 1'b1, 1'b0, 8'h00});
            @(posedge clk);
            #1;
        end
        m_grant = 1'b1;
        k = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (m_wr) begin
                k = i;
                break;
            end
        end
        check("t4_write_seen", {31'h0, (k >= 0)}, 32'h1);
        m_grant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("t4_wr_hold", {23'h0, m_req, m_wr, m_address}, {23'h0, 1'b1, 1'b1, 8'hC0});
            check("t4_dout_hold", m_dout, src_word(8'h50));
        end
        m_grant = 1'b1;
        wait_done(60, k);
        check("t4_done_seen", {31'h0, (k > 0)}, 32'h1);
        check("t4_queue_empty", exp_q.size(), 32'd0);

        // Reset during CAPT abandons the transfer.
        @(posedge clk);
        #1;
        do_start(8'h20, 8'h90, 8'd3);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_rst_outs", {m_req, m_wr, busy, done, m_address, 20'h0},
              {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 20'h0});
        check("t5_rst_dout", m_dout, 32'h0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) k++;
        end
        check("t5_no_done", k, 32'd0);
        do_start(8'h30, 8'hA0, 8'd2);
        wait_done(40, k);
        check("t5_latency", k, 32'd8);
        check("t5_queue_empty", exp_q.size(), 32'd0);

        // Maximum length with both pointers wrapping.
        @(posedge clk);
        #1;
        do_start(8'hF0, 8'hF8, 8'hFF);
        wait_done(900, k);
        check("t6_latency", k, 32'd767);
        check("t6_queue_empty", exp_q.size(), 32'd0);

`ifdef DMA_IRQ_EN
        // irq is sticky after earlier completions; clear it, then collide set with clear.
        check("irq_sticky", {31'h0, irq}, 32'h1);
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        check("irq_cleared", {31'h0, irq}, 32'h0);
        do_start(8'h60, 8'hD0, 8'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        check("irq_before_done", {31'h0, irq}, 32'h0);
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        check("irq_done", {31'h0, done}, 32'h1);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        @(posedge clk);
        #1;
        check("irq_stays", {31'h0, irq}, 32'h1);
        check("irq_queue_empty", exp_q.size(), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
